// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder:
// FSM states, MMIO page offsets and address-region decode.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REG_RAM   = 2'd0,
      REG_LED   = 2'd1,
      REG_CYCLE = 2'd2,
      REG_ERR   = 2'd3
   } region_t;

   localparam logic [31:0] LED_OFS   = 32'h0000_0000;
   localparam logic [31:0] CYCLE_OFS = 32'h0000_0004;

   function automatic logic is_misaligned(input logic [31:0] a);
      return (a[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/mem_responder_wordram.sv
// Word-wide RAM: synchronous write with enable, combinational read.
// Contents are deliberately not reset.
module wordram #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // storage array write port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Req/ack memory responder with programmable wait states, a word RAM and an
// I/O page holding an LED register and a free-running cycle counter.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        ack,
   output logic        err,
   output logic        busy,
   output logic [7:0]  leds
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_wait_cnt;
   logic [3:0]  w_wait_nxt;
   logic        w_enter_resp;

   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_acc_we;
   logic [31:0] w_acc_addr;
   logic [31:0] w_acc_wdata;
   region_t     w_region;
   logic [31:0] w_rd_val;

   logic          w_ram_we;
   logic [AW-1:0] w_ram_idx;
   logic [31:0]   w_ram_rdata;
   logic          w_led_we;
   logic          w_cyc_clr;

   logic [31:0] r_readdata;
   logic        r_ack;
   logic        r_err;
   logic        r_busy;
   logic [7:0]  r_leds;
   logic [31:0] r_cycle;

   // next-state and wait-counter logic
   always_comb begin
      w_state_nxt  = r_state;
      w_wait_nxt   = r_wait_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         IDLE: begin
            if (req) begin
               w_wait_nxt = WAIT_LD;
               if (WAIT_LD == 4'd0) begin
                  w_state_nxt  = RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (r_wait_cnt <= 4'd1) begin
               w_wait_nxt   = 4'd0;
               w_state_nxt  = RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_wait_nxt = r_wait_cnt - 4'd1;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_wait_nxt  = 4'd0;
         end
      endcase
   end

   // With zero wait states the access completes on the capture edge itself,
   // so the live inputs are used instead of the not-yet-captured copies.
   always_comb begin
      if (r_state == IDLE) begin
         w_acc_we    = memwrite;
         w_acc_addr  = addr;
         w_acc_wdata = writedata;
      end else begin
         w_acc_we    = r_we;
         w_acc_addr  = r_addr;
         w_acc_wdata = r_wdata;
      end
   end

   // address region decode
   always_comb begin
      w_region = REG_ERR;
      if (is_misaligned(w_acc_addr)) begin
         w_region = REG_ERR;
      end else if (w_acc_addr[31:AW+2] == '0) begin
         w_region = REG_RAM;
      end else if (w_acc_addr == (MMIO_BASE + LED_OFS)) begin
         w_region = REG_LED;
      end else if (w_acc_addr == (MMIO_BASE + CYCLE_OFS)) begin
         w_region = REG_CYCLE;
      end else begin
         w_region = REG_ERR;
      end
   end

   assign w_ram_idx = w_acc_addr[AW+1:2];

   // read-data selection, always from pre-write contents
   always_comb begin
      w_rd_val = 32'h0000_0000;
      case (w_region)
         REG_RAM:   w_rd_val = w_ram_rdata;
         REG_LED:   w_rd_val = {24'h00_0000, r_leds};
         REG_CYCLE: w_rd_val = r_cycle;
         default:   w_rd_val = 32'h0000_0000;
      endcase
   end

   // RAM is not reset, so its write strobe is gated while reset is held.
   assign w_ram_we  = w_enter_resp & w_acc_we & (w_region == REG_RAM) & reset;
   assign w_led_we  = w_enter_resp & w_acc_we & (w_region == REG_LED);
   assign w_cyc_clr = w_enter_resp & w_acc_we & (w_region == REG_CYCLE);

   wordram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_idx),
      .i_wdata (w_acc_wdata),
      .o_rdata (w_ram_rdata)
   );

   // FSM state, wait counter and registered handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_wait_cnt <= 4'd0;
         r_readdata <= 32'h0000_0000;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_ack      <= w_enter_resp;
         r_err      <= w_enter_resp & (w_region == REG_ERR);
         r_busy     <= (w_state_nxt != IDLE);
         if (w_enter_resp) begin
            r_readdata <= w_rd_val;
         end
      end
   end

   // request capture in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= 32'h0000_0000;
         r_wdata <= 32'h0000_0000;
      end else if ((r_state == IDLE) && req) begin
         r_we    <= memwrite;
         r_addr  <= addr;
         r_wdata <= writedata;
      end
   end

   // LED register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_leds <= 8'h00;
      end else if (w_led_we) begin
         r_leds <= w_acc_wdata[7:0];
      end
   end

   // free-running cycle counter; a write clears it and wins over the increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle <= 32'h0000_0000;
      end else if (w_cyc_clr) begin
         r_cycle <= 32'h0000_0000;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   assign readdata = r_readdata;
   assign ack      = r_ack;
   assign err      = r_err;
   assign busy     = r_busy;
   assign leds     = r_leds;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances with 0, 1 and 3 wait
// states, a scoreboard queue of expected responses and a vector table.
module tb_mem_responder;

   localparam logic [31:0] MB   = 32'hFFFF_0000;
   localparam int          NDUT = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NDUT-1:0]   req_v;
   logic              memwrite;
   logic [31:0]       addr;
   logic [31:0]       writedata;
   logic [31:0]       rd_v   [NDUT];
   logic [NDUT-1:0]   ack_v;
   logic [NDUT-1:0]   err_v;
   logic [NDUT-1:0]   busy_v;
   logic [7:0]        leds_v [NDUT];

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < NDUT; g++) begin : g_dut
         mem_responder #(
            .DEPTH       (64),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
            .MMIO_BASE   (MB)
         ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req       (req_v[g]),
            .memwrite  (memwrite),
            .addr      (addr),
            .writedata (writedata),
            .readdata  (rd_v[g]),
            .ack       (ack_v[g]),
            .err       (err_v[g]),
            .busy      (busy_v[g]),
            .leds      (leds_v[g])
         );
      end
   endgenerate

   function automatic int wc(input int k);
      case (k)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   typedef struct {
      int          sel;
      logic [31:0] rd;
      logic        chk_rd;
      logic        err;
      int          edge_n;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic        chk;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tb_edges = 0;

   always @(posedge clk) tb_edges <= tb_edges + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h (edge %0d)", name, act, exp, tb_edges);
      end
   endtask

   // response monitor: every ack pops one expected response
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < NDUT; k++) begin
         if (err_v[k] && !ack_v[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL err_without_ack: dut %0d err=1 ack=0 at edge %0d", k, tb_edges);
         end
         if (ack_v[k]) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: dut %0d ack=1 at edge %0d with nothing pending", k, tb_edges);
            end else begin
               e = sbq.pop_front();
               check32("ack_dut", 32'(k), 32'(e.sel));
               check32("ack_edge", 32'(tb_edges), 32'(e.edge_n));
               if (e.chk_rd) check32("readdata", rd_v[k], e.rd);
               check32("err", {31'd0, err_v[k]}, {31'd0, e.err});
            end
         end
      end
   end

   // single access; called at a negedge with the target idle, returns idle
   task automatic do_access(input int k, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic chk_rd,
                            input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      memwrite  = we;
      addr      = a;
      writedata = wd;
      req_v     = '0;
      req_v[k]  = 1'b1;
      e.sel    = k;
      e.rd     = exp_rd;
      e.chk_rd = chk_rd;
      e.err    = exp_err;
      e.edge_n = tb_edges + 1 + wc(k);
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_v = '0;
      repeat (wc(k) + 1) @(negedge clk);
   endtask

   vec_t        tbl [14];
   logic [31:0] exp_v;
   int          e_w;
   int          e_r;
   int          d_e;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      req_v = '0; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0; reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check32("rst_readdata", rd_v[k], 32'h0);
         check32("rst_ack", {31'd0, ack_v[k]}, 32'h0);
         check32("rst_err", {31'd0, err_v[k]}, 32'h0);
         check32("rst_busy", {31'd0, busy_v[k]}, 32'h0);
         check32("rst_leds", {24'd0, leds_v[k]}, 32'h0);
      end
      reset = 1'b1;
      @(negedge clk);

      // reset during WAIT drops the write (3 wait states)
      do_access(2, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
      do_access(2, 1'b1, MB, 32'h0000_003C, 1'b0, 32'h0, 1'b0);
      check32("led_pre_reset", {24'd0, leds_v[2]}, 32'h3C);
      memwrite = 1'b1; addr = 32'h10; writedata = 32'hDEAD_BEEF; req_v[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_v = '0;
      check32("busy_in_wait", {31'd0, busy_v[2]}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check32("busy_async_rst", {31'd0, busy_v[2]}, 32'h0);
      repeat (2) @(negedge clk);
      check32("leds_after_rst", {24'd0, leds_v[2]}, 32'h0);
      check32("ack_in_rst", {31'd0, ack_v[2]}, 32'h0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check32("busy_after_rst", {31'd0, busy_v[2]}, 32'h0);
      do_access(2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1111_1111, 1'b0);

      // vector table on the 1-wait-state instance
      tbl[0]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
      tbl[1]  = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
      tbl[2]  = '{1'b1, 32'h0000_0004, 32'hCAFE_0004, 1'b0, 32'h0,         1'b0};
      tbl[3]  = '{1'b1, 32'h0000_0006, 32'h0BAD_0BAD, 1'b1, 32'h0,         1'b1};
      tbl[4]  = '{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0,         1'b1};
      tbl[5]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'hCAFE_0004, 1'b0};
      tbl[6]  = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
      tbl[7]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         1'b1};
      tbl[8]  = '{1'b1, 32'h0000_0100, 32'h0000_0055, 1'b1, 32'h0,         1'b1};
      tbl[9]  = '{1'b0, MB + 32'h8,    32'h0,         1'b1, 32'h0,         1'b1};
      tbl[10] = '{1'b1, MB,            32'h0000_01A5, 1'b0, 32'h0,         1'b0};
      tbl[11] = '{1'b0, MB,            32'h0,         1'b1, 32'h0000_00A5, 1'b0};
      tbl[12] = '{1'b1, 32'h0000_00FC, 32'hA5A5_0001, 1'b0, 32'h0,         1'b0};
      tbl[13] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'hA5A5_0001, 1'b0};
      for (int i = 0; i < 14; i++) begin
         do_access(1, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].chk, tbl[i].rd, tbl[i].err);
      end
      check32("leds_after_write", {24'd0, leds_v[1]}, 32'h0000_00A5);
      check32("leds_other_dut", {24'd0, leds_v[0]}, 32'h0);

      // back-to-back with req held high, zero wait states
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         logic [31:0] a_l;
         logic [31:0] d_l;
         a_l = (i % 2 == 1) ? 32'h24 : 32'h20;
         d_l = (i % 2 == 1) ? 32'hB0B0_0024 : 32'hA0A0_0020;
         check32("b2b_busy_idle", {31'd0, busy_v[0]}, 32'h0);
         memwrite  = (i < 2);
         addr      = a_l;
         writedata = (i < 2) ? d_l : 32'h0;
         req_v[0]  = 1'b1;
         e.sel    = 0;
         e.rd     = d_l;
         e.chk_rd = (i >= 2);
         e.err    = 1'b0;
         e.edge_n = tb_edges + 1;
         sbq.push_back(e);
         @(negedge clk);
         check32("b2b_busy_resp", {31'd0, busy_v[0]}, 32'h1);
         check32("b2b_ack", {31'd0, ack_v[0]}, 32'h1);
         @(negedge clk);
      end
      req_v = '0;
      repeat (2) @(negedge clk);
      check32("b2b_drained", 32'(sbq.size()), 32'h0);

      // cycle counter: clear by write, read 5 cycles later
      e_w = tb_edges + 1 + wc(1);
      do_access(1, 1'b1, MB + 32'h4, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      e_r = tb_edges + 1 + wc(1);
      exp_v = 32'(e_r - e_w - 1);
      do_access(1, 1'b0, MB + 32'h4, 32'h0, 1'b1, exp_v, 1'b0);

      // counter wrap after a deposit near the top
      g_dut[2].u_dut.r_cycle <= 32'hFFFF_FFFE;
      d_e = tb_edges;
      repeat (2) @(negedge clk);
      e_r = tb_edges + 1 + wc(2);
      exp_v = 32'hFFFF_FFFE + 32'(e_r - d_e - 1);
      do_access(2, 1'b0, MB + 32'h4, 32'h0, 1'b1, exp_v, 1'b0);

      repeat (3) @(negedge clk);
      check32("scoreboard_drained", 32'(sbq.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
